// File: rtl/split_target_if.sv
// Initiator-to-target bus seen by a split-capable target.
// The master side covers both the initiator and the arbiter's resume grant.
interface split_target_if;
    logic        s_sel;
    logic [15:0] s_addr;
    logic        s_addr_valid;
    logic [7:0]  s_data_in;
    logic        s_data_in_valid;
    logic        s_rw;
    logic [7:0]  s_data_out;
    logic        s_data_out_valid;
    logic        s_ack;
    logic        s_split_ack;
    logic        s_split_req;
    logic        s_split_grant;
    logic        s_ready;

    modport master (
        output s_sel, s_addr, s_addr_valid, s_data_in, s_data_in_valid, s_rw, s_split_grant,
        input  s_data_out, s_data_out_valid, s_ack, s_split_ack, s_split_req, s_ready
    );

    modport slave (
        input  s_sel, s_addr, s_addr_valid, s_data_in, s_data_in_valid, s_rw, s_split_grant,
        output s_data_out, s_data_out_valid, s_ack, s_split_ack, s_split_req, s_ready
    );
endinterface

// File: rtl/split_target.sv
// Byte-memory bus target with programmable read latency and optional split reads.
// All handshake outputs are registered, so each appears one cycle after the state that produces it.
module split_target #(
    parameter int         ADDR_W       = 8,
    parameter int         READ_LATENCY = 3,
    parameter int         SPLIT_EN     = 1,
    parameter logic [7:0] MEM_INIT     = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    split_target_if.slave  bus
);
    localparam int         DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LAT   = 4'(READ_LATENCY);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_ACK, RD_WAIT, RD_SPLIT, RD_RESUME
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d;
    logic [7:0]          rdata_q, rdata_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ack_q, ack_d;
    logic                dv_q, dv_d;
    logic                split_ack_q, split_ack_d;
    logic                split_req_q, split_req_d;
    logic                ready;
    logic                unused_addr;

    logic [7:0] mem [DEPTH] = '{default: MEM_INIT};

    // Upper address bits alias away; fold them so they count as consumed.
    assign unused_addr = ^bus.s_addr;

    // The cycle carrying a registered ack is held off so acks never run back to back.
    assign ready = (state_q == IDLE) && !ack_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        dv_d        = 1'b0;
        split_ack_d = 1'b0;
        split_req_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ready && bus.s_sel && bus.s_addr_valid) begin
                    addr_d = bus.s_addr[ADDR_W-1:0];
                    if (bus.s_rw) begin
                        if (bus.s_data_in_valid) begin
                            wdata_d = bus.s_data_in;
                            state_d = WR_ACK;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end else begin
                        cnt_d   = LAT;
                        state_d = (SPLIT_EN != 0) ? RD_SPLIT : RD_WAIT;
                    end
                end
            end
            WR_DATA: begin
                if (bus.s_sel && bus.s_data_in_valid) begin
                    wdata_d = bus.s_data_in;
                    state_d = WR_ACK;
                end
            end
            WR_ACK: begin
                ack_d   = 1'b1;
                state_d = IDLE;
            end
            RD_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d = mem[addr_q];
                    dv_d    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            RD_SPLIT: begin
                cnt_d       = cnt_q - 4'd1;
                split_ack_d = (cnt_q == LAT);
                if (cnt_q == 4'd1) begin
                    split_req_d = 1'b1;
                    state_d     = RD_RESUME;
                end
            end
            RD_RESUME: begin
                if (bus.s_sel && bus.s_split_grant) begin
                    rdata_d = mem[addr_q];
                    dv_d    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    split_req_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= 8'h00;
            rdata_q     <= 8'h00;
            cnt_q       <= 4'd0;
            ack_q       <= 1'b0;
            dv_q        <= 1'b0;
            split_ack_q <= 1'b0;
            split_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            dv_q        <= dv_d;
            split_ack_q <= split_ack_d;
            split_req_q <= split_req_d;
        end
    end

    // Memory survives reset; an async reset forces IDLE so no write slips through.
    always_ff @(posedge clk) begin
        if (state_q == WR_ACK) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.s_data_out       = rdata_q;
    assign bus.s_data_out_valid = dv_q;
    assign bus.s_ack            = ack_q;
    assign bus.s_split_ack      = split_ack_q;
    assign bus.s_split_req      = split_req_q;
    assign bus.s_ready          = ready;
endmodule

// File: tb/tb_split_target.sv
// Directed bench: one non-split target (latency 3) and one split target (latency 4)
// share the initiator bus and are addressed through separate selects.
module tb_split_target;
    logic        clk;
    logic        rst;
    logic        sel_n, sel_s, av, dv, rw, grant;
    logic [15:0] addr;
    logic [7:0]  din;
    int          n_tests = 0;
    int          n_fail  = 0;

    split_target_if bn ();
    split_target_if bs ();

    assign bn.s_sel = sel_n;  assign bs.s_sel = sel_s;
    assign bn.s_addr = addr;  assign bs.s_addr = addr;
    assign bn.s_addr_valid = av;  assign bs.s_addr_valid = av;
    assign bn.s_data_in = din;  assign bs.s_data_in = din;
    assign bn.s_data_in_valid = dv;  assign bs.s_data_in_valid = dv;
    assign bn.s_rw = rw;  assign bs.s_rw = rw;
    assign bn.s_split_grant = grant;  assign bs.s_split_grant = grant;

    split_target #(.ADDR_W(8), .READ_LATENCY(3), .SPLIT_EN(0), .MEM_INIT(8'h00))
        u_nos (.clk(clk), .rst(rst), .bus(bn));
    split_target #(.ADDR_W(8), .READ_LATENCY(4), .SPLIT_EN(1), .MEM_INIT(8'h00))
        u_spl (.clk(clk), .rst(rst), .bus(bs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        sel_n = 1'b0; sel_s = 1'b0; av = 1'b0; dv = 1'b0; grant = 1'b0;
    endtask

    // Write to both targets; gap = cycles between address and data capture.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int gap);
        sel_n = 1'b1; sel_s = 1'b1; addr = a; av = 1'b1; rw = 1'b1; din = d; dv = (gap == 0);
        tick(); idle_bus();
        for (int i = 1; i <= gap; i++) begin
            chk("wr_wait_ack", {bn.s_ack, bs.s_ack}, 2'b00);
            if (i == gap) begin
                sel_n = 1'b1; sel_s = 1'b1; dv = 1'b1; din = d;
            end else begin
                dv = 1'b1; din = ~d;
            end
            tick(); idle_bus();
        end
        chk("wr_ack_early", {bn.s_ack, bs.s_ack}, 2'b00);
        tick();
        chk("wr_ack", {bn.s_ack, bs.s_ack}, 2'b11);
        chk("wr_ack_ready", {bn.s_ready, bs.s_ready}, 2'b00);
        tick();
        chk("wr_ack_end", {bn.s_ack, bs.s_ack}, 2'b00);
        chk("wr_ready", {bn.s_ready, bs.s_ready}, 2'b11);
    endtask

    task automatic read_nos(input logic [15:0] a, input logic [7:0] exp);
        sel_n = 1'b1; addr = a; av = 1'b1; rw = 1'b0;
        tick(); idle_bus();
        chk("rd_busy", bn.s_ready, 1'b0);
        chk("rd_other_idle", bs.s_ready, 1'b1);
        tick(); tick();
        chk("rd_early", {bn.s_data_out_valid, bn.s_ack}, 2'b00);
        tick();
        chk("rd_resp", {bn.s_data_out_valid, bn.s_ack}, 2'b11);
        chk("rd_data", bn.s_data_out, exp);
        tick();
        chk("rd_pulse", {bn.s_data_out_valid, bn.s_ack}, 2'b00);
        chk("rd_hold", bn.s_data_out, exp);
    endtask

    // Split read with an ignored write attempt while busy; grant withheld for hold cycles.
    task automatic split_read(input logic [15:0] a, input logic [7:0] exp, input int hold);
        sel_s = 1'b1; addr = a; av = 1'b1; rw = 1'b0;
        tick(); idle_bus();
        chk("sp_ack_e0", bs.s_split_ack, 1'b0);
        tick();
        chk("sp_ack", {bs.s_split_ack, bs.s_ack, bs.s_split_req}, 3'b100);
        sel_s = 1'b1; addr = 16'h0012; av = 1'b1; rw = 1'b1; din = 8'h77; dv = 1'b1;
        tick(); idle_bus();
        chk("sp_ack_end", bs.s_split_ack, 1'b0);
        chk("sp_busy", bs.s_ready, 1'b0);
        tick();
        chk("sp_req_early", bs.s_split_req, 1'b0);
        tick();
        chk("sp_req", bs.s_split_req, 1'b1);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("sp_req_hold", {bs.s_split_req, bs.s_ack, bs.s_data_out_valid}, 3'b100);
        end
        sel_s = 1'b1; grant = 1'b1;
        tick(); idle_bus();
        chk("sp_resp", {bs.s_split_req, bs.s_data_out_valid, bs.s_ack}, 3'b011);
        chk("sp_data", bs.s_data_out, exp);
        tick();
        chk("sp_pulse", {bs.s_data_out_valid, bs.s_ack}, 2'b00);
        chk("sp_ready", bs.s_ready, 1'b1);
    endtask

    initial begin
        rst = 1'b1; idle_bus(); rw = 1'b0; addr = 16'h0; din = 8'h0;
        tick(); tick();
        chk("rst_ready", {bn.s_ready, bs.s_ready}, 2'b11);
        chk("rst_pulses", {bn.s_ack, bn.s_data_out_valid, bs.s_ack, bs.s_split_ack, bs.s_split_req}, 5'b0);
        chk("rst_data", {bn.s_data_out, bs.s_data_out}, 16'h0000);
        rst = 1'b0;
        tick();

        do_write(16'h0012, 8'hAA, 0);
        do_write(16'h0034, 8'h5C, 3);
        read_nos(16'h0034, 8'h5C);
        read_nos(16'hFF34, 8'h5C);
        read_nos(16'h0012, 8'hAA);
        split_read(16'h0112, 8'hAA, 5);

        // Abort a split read while it waits for its grant.
        sel_s = 1'b1; addr = 16'h0012; av = 1'b1; rw = 1'b0;
        tick(); idle_bus();
        repeat (4) tick();
        chk("abort_req_before", bs.s_split_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_outputs", {bs.s_split_req, bs.s_ack, bs.s_data_out_valid, bs.s_split_ack}, 4'b0);
        chk("abort_ready", bs.s_ready, 1'b1);
        chk("abort_data", {bn.s_data_out, bs.s_data_out}, 16'h0000);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_quiet", {bs.s_split_req, bs.s_ack, bs.s_data_out_valid}, 3'b000);
        end

        split_read(16'h0012, 8'hAA, 0);
        read_nos(16'h0012, 8'hAA);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/split_target.md
Name: split_target

Overview:
- Bus target (slave) that sits directly downstream of the bus initiator through the arbiter/decoder.
- Receives address, write data and rw over the granted bus; stores writes in local byte memory; returns read data with programmable latency.
- Optional split mode: target releases the bus during read latency, then requests the bus back to deliver data together with ack.

Parameters:
ADDR_W, 8, local address bits taken from s_addr[ADDR_W-1:0]; memory depth is 2**ADDR_W
READ_LATENCY, 3, cycles from read address capture to data ready; legal range 1..15, and 2..15 when SPLIT_EN=1
SPLIT_EN, 1, 1 = every read is split; 0 = bus held until data returned
MEM_INIT, 8'h00, reset-independent initial value of every memory byte (time-0 init only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
s_sel  in  1  decoder select; this target is addressed
s_addr  in  16  address from initiator
s_addr_valid  in  1  address valid
s_data_in  in  8  write data from initiator
s_data_in_valid  in  1  write data valid
s_rw  in  1  1 = write, 0 = read; sampled with address
s_data_out  out  8  read data to initiator
s_data_out_valid  out  1  read data valid, one-cycle pulse
s_ack  out  1  transaction complete, one-cycle pulse
s_split_ack  out  1  split issued, one-cycle pulse; initiator drops its request
s_split_req  out  1  request to arbiter to resume the split transaction
s_split_grant  in  1  arbiter grants resume
s_ready  out  1  high only in IDLE

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0 except s_ready=1; s_data_out=8'h00; latency counter 0. Memory contents are not reset. Reset during any state aborts the transaction: no ack and no split_req afterwards.
- All inputs are qualified by s_sel; any input with s_sel=0 is ignored.
- Unused upper address bits are ignored, so addresses alias modulo 2**ADDR_W.
- IDLE:
  - On s_sel & s_addr_valid, latch the local address and s_rw.
  - Write with s_data_in_valid in the same cycle: latch data, go to WR_ACK.
  - Write without data: go to WR_DATA.
  - Read: load counter = READ_LATENCY, go to RD_WAIT (SPLIT_EN=0) or RD_SPLIT (SPLIT_EN=1).
  - s_data_in_valid without s_addr_valid is ignored.
- WR_DATA: wait for s_sel & s_data_in_valid; latch data, go to WR_ACK. No timeout.
- WR_ACK: memory written at the end of this cycle; s_ack=1 for exactly this cycle; go to IDLE. A read issued next cycle to the same address returns the new value.
- RD_WAIT (no split):
  - Counter decrements every cycle. When it reaches 0, s_data_out=mem[addr], s_data_out_valid=1 and s_ack=1 together for one cycle, then IDLE.
  - Address captured at edge E0 gives the response in the cycle beginning at edge E0+READ_LATENCY.
- RD_SPLIT:
  - s_split_ack=1 for the first cycle (from edge E0+1); counter decrements.
  - When the counter reaches 0, go to RD_RESUME with s_split_req=1 (from edge E0+READ_LATENCY).
- RD_RESUME: s_split_req held high until s_split_grant is sampled high. The next cycle drives s_split_req=0 with s_data_out_valid=1 and s_ack=1 together for one cycle, then IDLE.
- Read data is sampled from memory when the response is driven. A write cannot intervene because s_ready=0.
- While busy (s_ready=0), any s_addr_valid is ignored. No queueing and no error response.
- s_split_grant outside RD_RESUME is ignored.
- s_data_out holds its last value when s_data_out_valid=0.
- s_ack, s_data_out_valid and s_split_ack are never high for more than one consecutive cycle. s_split_ack and s_ack are never high in the same cycle.

Test Plan:
- Write addr 16'h0012, data 8'hAA with addr and data valid in the same cycle -> s_ack pulse at edge E0+1; a later read of 16'h0012 returns 8'hAA.
- Write with data_valid arriving 3 cycles after addr_valid, data 8'h5C to 16'h0034 -> no ack until data; s_ack exactly 1 cycle after data capture.
- SPLIT_EN=0, READ_LATENCY=3, read 16'h0034 after the 8'h5C write -> s_data_out=8'h5C with s_ack and data_valid high together in cycle E0+3, 1 cycle wide.
- SPLIT_EN=1, READ_LATENCY=4, read 16'h0112 (aliases 8'h12) -> s_split_ack at E0+1; s_split_req from E0+4; grant held off 5 cycles keeps split_req high; after grant, data 8'hAA with s_ack, split_req low.
- Second s_addr_valid during RD_SPLIT (s_ready=0) -> ignored; memory unchanged; only the original transaction completes.
- rst asserted while in RD_RESUME -> outputs 0 immediately, s_ready=1; no ack follows; memory retains 8'hAA at 8'h12.
